// File: rtl/minibyte_bus_responder.sv
// minibyte_bus_responder
//   Memory-side responder for the minibyte CPU external bus. CPU read/write
//   requests are served from an internal RAM of DEPTH bytes. Each transfer
//   waits WAIT_STATES cycles, then gives a one-cycle ack, then waits for the
//   CPU to drop its request (four-phase handshake). A host port preloads the
//   RAM while the responder is idle.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset (RAM contents are kept)
//   bus_req    : CPU request level, held until ack is seen
//   bus_we     : 1 = write, 0 = read (valid with bus_req)
//   bus_addr   : word address (valid with bus_req)
//   bus_wdata  : write data (valid with bus_req & bus_we)
//   bus_rdata  : read data, or the written data on writes; held between acks
//   bus_ack    : one-cycle completion pulse
//   bus_err    : pulses with bus_ack for addresses >= DEPTH
//   busy       : high from request capture until return to idle
//   prog_en    : host preload write strobe (honoured only when idle)
//   prog_addr  : host preload address
//   prog_data  : host preload data
module minibyte_bus_responder #(
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_req,
  input  logic       bus_we,
  input  logic [7:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_ack,
  output logic       bus_err,
  output logic       busy,
  input  logic       prog_en,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [7:0]  addr_reg;
  logic [7:0]  wdata_reg;
  logic        we_reg;
  logic        busy_reg;
  logic        ack_reg;
  logic        err_reg;
  logic [7:0]  rdata_reg;

  logic [7:0]  mem [DEPTH];

  logic        capture;
  logic        enter_resp;
  logic [7:0]  cur_addr;
  logic [7:0]  cur_wdata;
  logic        cur_we;
  logic        cur_in_range;
  logic [AW-1:0] rd_idx;
  logic        prog_in_range;
  logic        resp_in_range;
  logic        mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]  mem_wdata;

  // Full 8-bit compare so that out-of-range addresses never alias into the RAM.
  function automatic logic addr_ok(input logic [7:0] a);
    return {1'b0, a} < 9'(DEPTH);
  endfunction

  // A host write in idle takes the cycle; the request is captured afterwards.
  assign capture = (state_reg == IDLE) && !prog_en && bus_req;

  // With zero wait states the response is prepared on the capture edge itself,
  // before the latched copies exist, so the live bus fields are used then.
  assign enter_resp = (capture && (WAIT_STATES == 0)) ||
                      ((state_reg == WAIT) && (cnt_reg == 4'd1));

  assign cur_addr     = (state_reg == IDLE) ? bus_addr  : addr_reg;
  assign cur_wdata    = (state_reg == IDLE) ? bus_wdata : wdata_reg;
  assign cur_we       = (state_reg == IDLE) ? bus_we    : we_reg;
  assign cur_in_range = addr_ok(cur_addr);
  assign rd_idx       = cur_addr[AW-1:0];

  assign prog_in_range = addr_ok(prog_addr);
  assign resp_in_range = addr_ok(addr_reg);

  // Single write port shared by host preload (IDLE) and CPU writes (RESP);
  // the two states are exclusive. Reset blocks the CPU write in RESP.
  assign mem_we    = !rst && (((state_reg == IDLE) && prog_en && prog_in_range) ||
                              ((state_reg == RESP) && we_reg && resp_in_range));
  assign mem_waddr = (state_reg == RESP) ? addr_reg[AW-1:0] : prog_addr[AW-1:0];
  assign mem_wdata = (state_reg == RESP) ? wdata_reg : prog_data;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read: loaded on the edge that enters RESP, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= 8'h00;
    end else if (enter_resp) begin
      if (cur_we) begin
        rdata_reg <= cur_wdata;
      end else if (cur_in_range) begin
        rdata_reg <= mem[rd_idx];
      end else begin
        rdata_reg <= 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (capture) begin
          if (WAIT_STATES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: state_next = HOLD;
      HOLD: begin
        if (!bus_req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= 1'b0;
      ack_reg  <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      ack_reg <= enter_resp;
      err_reg <= enter_resp && !cur_in_range;
      if (capture) begin
        busy_reg <= 1'b1;
      end else if ((state_reg == HOLD) && !bus_req) begin
        busy_reg <= 1'b0;
      end
    end
  end

  // Request fields are only meaningful after capture, so they carry no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_reg  <= bus_addr;
      wdata_reg <= bus_wdata;
      we_reg    <= bus_we;
    end
  end

  assign bus_rdata = rdata_reg;
  assign bus_ack   = ack_reg;
  assign bus_err   = err_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_minibyte_bus_responder.sv
// Testbench for minibyte_bus_responder: a fixed table of transfers with
// hand-derived expectations, hand sequences for handshake corner cases, and
// a randomized phase checked against a byte-array memory model.
module tb_minibyte_bus_responder;

  localparam int DEPTH = 16;
  localparam int WS    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       bus_req;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic       bus_err;
  logic       busy;
  logic       prog_en;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mem_model [256];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs [11];

  minibyte_bus_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err),
    .busy      (busy),
    .prog_en   (prog_en),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host preload in idle; the model follows the full-address rule.
  task automatic prog(input logic [7:0] a, input logic [7:0] d);
    prog_en   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_en = 1'b0;
    if (a < DEPTH) mem_model[a] = d;
    $display("prog  addr=%02h data=%02h", a, d);
  endtask

  // Expected response computed from the transfer rules, then the model updated.
  task automatic model_xfer(input logic we, input logic [7:0] a, input logic [7:0] d,
                            output logic [7:0] rd, output logic err);
    err = (a >= DEPTH);
    if (we) rd = d;
    else    rd = err ? 8'h00 : mem_model[a];
    if (we && !err) mem_model[a] = d;
  endtask

  // One complete four-phase transfer with latency, data, hold and release checks.
  task automatic xfer(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                      input int hold, input bit drop, input bit prog_same,
                      input logic [7:0] paddr, input logic [7:0] pdata, input bit noise,
                      input logic [7:0] exp_rd, input logic exp_err, input string tag);
    int n;
    int exp_lat;
    bit got;
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    if (prog_same) begin
      prog_en   = 1'b1;
      prog_addr = paddr;
      prog_data = pdata;
    end
    exp_lat = 1 + WS + (prog_same ? 1 : 0);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      prog_en = 1'b0;
      if (bus_ack) begin
        got = 1'b1;
      end else if (n == 1 && !prog_same) begin
        if (drop) bus_req = 1'b0;
        if (noise) begin
          // Transfer already captured: these must all be ignored.
          prog_en   = 1'b1;
          prog_addr = 8'($urandom_range(0, DEPTH - 1));
          prog_data = 8'($urandom);
          bus_addr  = 8'($urandom);
          bus_wdata = 8'($urandom);
          bus_we    = 1'($urandom);
        end
      end
    end
    prog_en = 1'b0;
    $display("xfer  %s we=%0d addr=%02h wdata=%02h -> rdata=%02h err=%0d lat=%0d",
             tag, we, addr, wdata, bus_rdata, bus_err, n);
    chk({tag, " ack_seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " rdata"}, 32'(bus_rdata), 32'(exp_rd));
    chk({tag, " err"}, 32'(bus_err), 32'(exp_err));
    chk({tag, " busy_at_ack"}, 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, " no_repeat_ack"}, 32'(bus_ack), 32'd0);
      chk({tag, " busy_in_hold"}, 32'(busy), 32'd1);
    end
    bus_req = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    chk({tag, " released"}, 32'(busy), 32'd0);
    chk({tag, " rdata_held"}, 32'(bus_rdata), 32'(exp_rd));
  endtask

  task automatic xfer_model(input logic we, input logic [7:0] a, input logic [7:0] d,
                            input int hold, input bit drop, input bit noise, input string tag);
    logic [7:0] rd;
    logic err;
    model_xfer(we, a, d, rd, err);
    xfer(we, a, d, hold, drop, 1'b0, 8'h00, 8'h00, noise, rd, err, tag);
  endtask

  initial begin
    logic [7:0] rd;
    logic       err;
    int         n;
    bit         got;

    vecs[0]  = '{1'b0, 8'h03, 8'h00, 8'hA5, 1'b0};
    vecs[1]  = '{1'b1, 8'h05, 8'h3C, 8'h3C, 1'b0};
    vecs[2]  = '{1'b0, 8'h05, 8'h00, 8'h3C, 1'b0};
    vecs[3]  = '{1'b0, 8'h20, 8'h00, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 8'h20, 8'hFF, 8'hFF, 1'b1};
    vecs[5]  = '{1'b0, 8'h0F, 8'h00, 8'h1F, 1'b0};
    vecs[6]  = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 8'h00, 8'h10, 1'b0};
    vecs[8]  = '{1'b1, 8'h0F, 8'h77, 8'h77, 1'b0};
    vecs[9]  = '{1'b0, 8'h0F, 8'h00, 8'h77, 1'b0};
    vecs[10] = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1};

    for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;

    rst = 1'b1;
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = 8'h00; bus_wdata = 8'h00;
    prog_en = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
    repeat (3) tick();
    chk("reset ack", 32'(bus_ack), 32'd0);
    chk("reset err", 32'(bus_err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rdata", 32'(bus_rdata), 32'd0);
    rst = 1'b0;
    tick();

    // Preload: mem[i] = 0x10+i, then an out-of-range preload that must not alias.
    for (int i = 0; i < DEPTH; i++) prog(8'(i), 8'(8'h10 + i));
    prog(8'h30, 8'h99);
    prog(8'h03, 8'hA5);
    prog(8'h07, 8'h11);

    for (int i = 0; i < 11; i++) begin
      model_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, err);
      xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0,
           vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Request dropped while waiting still completes.
    xfer(1'b1, 8'h06, 8'hC3, 0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'hC3, 1'b0, "drop_wr");
    mem_model[6] = 8'hC3;
    xfer(1'b0, 8'h06, 8'h00, 0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'hC3, 1'b0, "drop_rd");

    // Whole RAM unaffected by out-of-range writes.
    for (int a = 0; a < DEPTH; a++) xfer_model(1'b0, 8'(a), 8'h00, 0, 1'b0, 1'b0, $sformatf("sweep%0d", a));

    // Request held high for 10 cycles after ack.
    xfer(1'b0, 8'h02, 8'h00, 10, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h12, 1'b0, "hold10");

    // Host preload and request together: preload first, capture one cycle later.
    xfer(1'b0, 8'h08, 8'h00, 0, 1'b0, 1'b1, 8'h08, 8'h5E, 1'b0, 8'h5E, 1'b0, "prog_req");
    mem_model[8] = 8'h5E;

    // Reset during RESP of a write to 0x07 (holds 0x11).
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 8'h07; bus_wdata = 8'hEE;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (bus_ack) got = 1'b1;
    end
    chk("rst_resp ack_seen", 32'(got), 32'd1);
    rst = 1'b1;
    tick();
    $display("xfer  rst_in_resp addr=07 wdata=EE -> ack=%0d busy=%0d rdata=%02h", bus_ack, busy, bus_rdata);
    chk("rst_resp ack", 32'(bus_ack), 32'd0);
    chk("rst_resp err", 32'(bus_err), 32'd0);
    chk("rst_resp busy", 32'(busy), 32'd0);
    chk("rst_resp rdata", 32'(bus_rdata), 32'd0);
    rst = 1'b0;
    bus_req = 1'b0;
    tick();
    chk("rst_resp no_late_ack", 32'(bus_ack), 32'd0);
    xfer(1'b0, 8'h07, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h11, 1'b0, "after_rst");

    // Randomized transfers against the model.
    for (int t = 0; t < 120; t++) begin
      logic       we;
      logic [7:0] a;
      int         hold;
      bit         drop;
      we   = 1'($urandom);
      a    = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 17));
      hold = $urandom_range(0, 3);
      drop = (hold == 0) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 4) == 0) prog(8'($urandom_range(0, 31)), 8'($urandom));
      xfer_model(we, a, 8'($urandom), hold, drop, 1'($urandom), $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
